// File: rtl/uart_output_handler.sv
// rtl/uart_output_handler.sv - Serializes status/address/data words into an ASCII-hex UART response frame.
// Optional CR/LF trailer after the data nibbles: define UART_OUT_CRLF_EN.
module uart_output_handler #(
   parameter logic [7:0] ID_CHAR = 8'h53
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] status,
   input  logic [31:0] address,
   input  logic [31:0] data,
   output logic        ready,
   output logic        finished,
   output logic [7:0]  uart_byte,
   output logic        uart_send,
   input  logic        uart_busy
);

`ifdef UART_OUT_CRLF_EN
   localparam logic [4:0] LAST_IDX = 5'd26;
`else
   localparam logic [4:0] LAST_IDX = 5'd24;
`endif
   localparam logic [4:0] LAST_NIB_IDX = 5'd24;

   typedef enum logic [2:0] {IDLE, SEND, HOLD, WAIT_TX, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] status_q, status_d;
   logic [31:0] address_q, address_d;
   logic [31:0] data_q, data_d;
   logic [4:0]  idx_q, idx_d;
   logic [7:0]  byte_q, byte_d;
   logic [7:0]  cur_char;
   logic [3:0]  nib;

   // The three words shift as one 96-bit chain, so the next nibble is always status_q[31:28].
   assign nib = status_q[31:28];

   always_comb begin
      cur_char = ID_CHAR;
      if (idx_q == 5'd0) begin
         cur_char = ID_CHAR;
      end else if (idx_q <= LAST_NIB_IDX) begin
         cur_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
`ifdef UART_OUT_CRLF_EN
      end else if (idx_q == 5'd25) begin
         cur_char = 8'h0D;
      end else begin
         cur_char = 8'h0A;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      status_d  = status_q;
      address_d = address_q;
      data_d    = data_q;
      idx_d     = idx_q;
      byte_d    = byte_q;
      ready     = 1'b0;
      finished  = 1'b0;
      uart_send = 1'b0;
      uart_byte = byte_q;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            idx_d = 5'd0;
            if (start) begin
               status_d  = status;
               address_d = address;
               data_d    = data;
               state_d   = SEND;
            end
         end
         SEND: begin
            if (!uart_busy) begin
               uart_send = 1'b1;
               uart_byte = cur_char;
               byte_d    = cur_char;
               if (idx_q != 5'd0 && idx_q <= LAST_NIB_IDX) begin
                  status_d  = {status_q[27:0], address_q[31:28]};
                  address_d = {address_q[27:0], data_q[31:28]};
                  data_d    = {data_q[27:0], 4'h0};
               end
               state_d = HOLD;
            end
         end
         // Gives the transmitter a cycle to raise busy before it is looked at.
         HOLD: state_d = WAIT_TX;
         WAIT_TX: begin
            if (!uart_busy) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = SEND;
               end
            end
         end
         DONE: begin
            finished = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         status_q  <= 32'h0;
         address_q <= 32'h0;
         data_q    <= 32'h0;
         idx_q     <= 5'd0;
         byte_q    <= 8'h00;
      end else begin
         state_q   <= state_d;
         status_q  <= status_d;
         address_q <= address_d;
         data_q    <= data_d;
         idx_q     <= idx_d;
         byte_q    <= byte_d;
      end
   end

endmodule

// File: tb/tb_uart_output_handler.sv
// tb/tb_uart_output_handler.sv - Self-checking bench for uart_output_handler.
`timescale 1ns/1ps
module tb_uart_output_handler;

`ifdef UART_OUT_CRLF_EN
   localparam int LEN = 27;
`else
   localparam int LEN = 25;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] status = 32'h0;
   logic [31:0] address = 32'h0;
   logic [31:0] data = 32'h0;
   logic        ready;
   logic        finished;
   logic [7:0]  uart_byte;
   logic        uart_send;
   logic        uart_busy = 1'b0;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int busy_len = 0;
   int fin_cnt = 0;
   int fin_cyc = 0;
   int viol = 0;
   logic [7:0] sent_q[$];
   int         send_cyc_q[$];
   logic [7:0] exp_q[$];

   uart_output_handler dut (
      .clk(clk), .rst(rst), .start(start), .status(status), .address(address), .data(data),
      .ready(ready), .finished(finished), .uart_byte(uart_byte), .uart_send(uart_send),
      .uart_busy(uart_busy)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (uart_send) begin
         sent_q.push_back(uart_byte);
         send_cyc_q.push_back(cyc);
         if (uart_busy) viol++;
      end
      if (finished) begin
         fin_cnt++;
         fin_cyc = cyc;
      end
   end

   // Transmitter model: busy rises the cycle after a send and stays up busy_len cycles.
   initial forever begin
      @(negedge clk);
      if (uart_send && busy_len > 0) begin
         @(posedge clk);
         #1 uart_busy = 1'b1;
         repeat (busy_len) @(posedge clk);
         #1 uart_busy = 1'b0;
      end
   end

   task automatic clear_mon();
      sent_q.delete();
      send_cyc_q.delete();
      exp_q.delete();
      fin_cnt = 0;
      viol = 0;
   endtask

   task automatic model_frame(input logic [31:0] s, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] w[3];
      int n;
      w[0] = s; w[1] = a; w[2] = d;
      exp_q.push_back(8'h53);
      for (int k = 0; k < 3; k++) begin
         for (int i = 7; i >= 0; i--) begin
            n = int'((w[k] >> (4 * i)) & 32'hF);
            exp_q.push_back(n < 10 ? 8'(48 + n) : 8'(65 + (n - 10)));
         end
      end
`ifdef UART_OUT_CRLF_EN
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
`endif
   endtask

   function automatic int first_diff();
      int n;
      n = (sent_q.size() < exp_q.size()) ? sent_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (sent_q[i] !== exp_q[i]) return i;
      if (sent_q.size() != exp_q.size()) return n;
      return -1;
   endfunction

   task automatic start_frame(input logic [31:0] s, input logic [31:0] a, input logic [31:0] d);
      for (int i = 0; i < 1000 && ready !== 1'b1; i++) @(negedge clk);
      @(posedge clk);
      #1;
      status = s; address = a; data = d; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (finished === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if ({ready, uart_send, finished, uart_byte} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_outputs: ready/send/fin/byte=%b/%b/%b/%h required 1/0/0/00",
                     ready, uart_send, finished, uart_byte);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b required 1", ready);
      end
   endtask

   task automatic test_basic();
      bit to;
      int mn, mx;
      busy_len = 0;
      clear_mon();
      model_frame(32'h00000001, 32'hDEADBEEF, 32'h0123ABCD);
      start_frame(32'h00000001, 32'hDEADBEEF, 32'h0123ABCD);
      wait_done(500, to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL basic_timeout: finished not seen within 500 cycles"); end
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: got %b required 1", ready); end
      n_checks++;
      if (first_diff() != -1) begin
         n_fail++;
         $display("FAIL basic_content: first diff at %0d, sent %0d chars required %0d", first_diff(), sent_q.size(), LEN);
      end
      n_checks++;
      if (fin_cnt != 1) begin n_fail++; $display("FAIL basic_fin_count: got %0d required 1", fin_cnt); end
      if (send_cyc_q.size() == LEN) begin
         mn = 1000; mx = 0;
         for (int i = 1; i < LEN; i++) begin
            if (send_cyc_q[i] - send_cyc_q[i-1] < mn) mn = send_cyc_q[i] - send_cyc_q[i-1];
            if (send_cyc_q[i] - send_cyc_q[i-1] > mx) mx = send_cyc_q[i] - send_cyc_q[i-1];
         end
         n_checks++;
         if (mn != 3 || mx != 3) begin n_fail++; $display("FAIL basic_spacing: min %0d max %0d required 3", mn, mx); end
         n_checks++;
         if (fin_cyc - send_cyc_q[0] != 3 * LEN) begin
            n_fail++;
            $display("FAIL basic_duration: first send to finished %0d required %0d", fin_cyc - send_cyc_q[0], 3 * LEN);
         end
         n_checks++;
         if (fin_cyc - send_cyc_q[LEN-1] != 3) begin
            n_fail++;
            $display("FAIL basic_fin_after_last: %0d cycles required 3", fin_cyc - send_cyc_q[LEN-1]);
         end
      end
   endtask

   task automatic test_encoding();
      bit to;
      int f;
      busy_len = 0;
      clear_mon();
      model_frame(32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF);
      start_frame(32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF);
      wait_done(500, to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL enc_timeout: finished not seen"); end
      n_checks++;
      if (first_diff() != -1) begin n_fail++; $display("FAIL enc_content: first diff at %0d", first_diff()); end
      f = 0;
      for (int i = 17; i < 25 && i < sent_q.size(); i++) if (sent_q[i] === 8'h46) f++;
      n_checks++;
      if (f != 8) begin n_fail++; $display("FAIL enc_data_F: got %0d chars of 0x46 required 8", f); end
   endtask

   task automatic test_busy_stall();
      bit to;
      int mn;
      busy_len = 160;
      clear_mon();
      model_frame(32'h00000001, 32'hDEADBEEF, 32'h0123ABCD);
      start_frame(32'h00000001, 32'hDEADBEEF, 32'h0123ABCD);
      wait_done(LEN * 170 + 200, to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL stall_timeout: finished not seen"); end
      n_checks++;
      if (first_diff() != -1) begin n_fail++; $display("FAIL stall_content: first diff at %0d", first_diff()); end
      n_checks++;
      if (viol != 0) begin n_fail++; $display("FAIL stall_send_while_busy: got %0d required 0", viol); end
      mn = 100000;
      for (int i = 1; i < send_cyc_q.size(); i++)
         if (send_cyc_q[i] - send_cyc_q[i-1] < mn) mn = send_cyc_q[i] - send_cyc_q[i-1];
      n_checks++;
      if (mn < 162) begin n_fail++; $display("FAIL stall_spacing: min %0d required >=162", mn); end
      busy_len = 0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_ignored_start();
      bit to;
      logic [31:0] s, a, d;
      busy_len = 0;
      clear_mon();
      s = $urandom; a = $urandom; d = $urandom;
      model_frame(s, a, d);
      start_frame(s, a, d);
      for (int i = 0; i < 200 && send_cyc_q.size() < 10; i++) @(negedge clk);
      @(posedge clk);
      #1;
      status = ~s; address = ~a; data = ~d; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(500, to);
      repeat (120) @(negedge clk);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL ign_timeout: finished not seen"); end
      n_checks++;
      if (first_diff() != -1) begin
         n_fail++;
         $display("FAIL ign_content: first diff at %0d, sent %0d chars required %0d", first_diff(), sent_q.size(), LEN);
      end
      n_checks++;
      if (fin_cnt != 1) begin n_fail++; $display("FAIL ign_fin_count: got %0d required 1", fin_cnt); end
   endtask

   task automatic test_reset_midframe();
      bit to;
      int n;
      logic [31:0] s, a, d;
      busy_len = 0;
      clear_mon();
      start_frame(32'h00000001, 32'hDEADBEEF, 32'h0123ABCD);
      n = 0;
      for (int i = 0; i < 200 && n < 12; i++) begin
         @(negedge clk);
         if (uart_send) n++;
      end
      #1 rst = 1'b0;
      #1;
      n_checks++;
      if ({uart_send, uart_byte, ready} !== {1'b0, 8'h00, 1'b1}) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: send/byte/ready=%b/%h/%b required 0/00/1", uart_send, uart_byte, ready);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (100) @(negedge clk);
      n_checks++;
      if (fin_cnt != 0) begin n_fail++; $display("FAIL rst_mid_no_finish: got %0d required 0", fin_cnt); end
      n_checks++;
      if (sent_q.size() != 12) begin n_fail++; $display("FAIL rst_mid_abandon: sent %0d required 12", sent_q.size()); end
      clear_mon();
      s = $urandom; a = $urandom; d = $urandom;
      model_frame(s, a, d);
      start_frame(s, a, d);
      wait_done(500, to);
      n_checks++;
      if (to || first_diff() != -1) begin
         n_fail++;
         $display("FAIL rst_mid_restart: timeout %0d first diff %0d required 0/-1", to, first_diff());
      end
   endtask

   task automatic test_back_to_back();
      bit to;
      logic [31:0] s, a, d;
      busy_len = 0;
      clear_mon();
      s = $urandom; a = $urandom; d = $urandom;
      model_frame(s, a, d);
      start_frame(s, a, d);
      wait_done(500, to);
      s = $urandom; a = $urandom; d = $urandom;
      model_frame(s, a, d);
      @(posedge clk);
      #1;
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b required 1", ready); end
      status = s; address = a; data = d; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(500, to);
      @(negedge clk);
      n_checks++;
      if (to || fin_cnt != 2) begin n_fail++; $display("FAIL b2b_fin: timeout %0d count %0d required 0/2", to, fin_cnt); end
      n_checks++;
      if (first_diff() != -1) begin n_fail++; $display("FAIL b2b_content: first diff at %0d", first_diff()); end
   endtask

   task automatic test_random();
      bit to;
      logic [31:0] s, a, d;
      for (int f = 0; f < 4; f++) begin
         busy_len = int'($urandom_range(0, 4));
         clear_mon();
         s = $urandom; a = $urandom; d = $urandom;
         model_frame(s, a, d);
         start_frame(s, a, d);
         wait_done(1000, to);
         n_checks++;
         if (to || first_diff() != -1 || viol != 0) begin
            n_fail++;
            $display("FAIL rand_frame%0d: timeout %0d first diff %0d busy viol %0d required 0/-1/0", f, to, first_diff(), viol);
         end
         busy_len = 0;
         repeat (10) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_encoding();
      test_busy_stall();
      test_ignored_start();
      test_reset_midframe();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
